// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - NES pad poller producing a parallel button word; NES_TWO_PAD_EN adds pad 2
module nes_pad_reader #(
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300,
  parameter int POLL_CYC  = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nes_data,
`ifdef NES_TWO_PAD_EN
  input  logic        nes_data2,
`endif
  output logic        nes_latch,
  output logic        nes_clk,
  output logic [15:0] buttons,
  output logic        frame_valid
);

  localparam int PW   = $clog2(POLL_CYC);
  localparam int CMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_HI, S_LO, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic          sample;
  logic          poll_tick;
  logic          last_latch;
  logic          last_half;
  logic [1:0]    sync1;
  logic [7:0]    shreg1;
  logic [7:0]    pad2_word;

  assign poll_tick  = (poll_cnt == PW'(POLL_CYC - 1));
  assign last_latch = (cyc_cnt == CW'(LATCH_CYC - 1));
  assign last_half  = (cyc_cnt == CW'(HALF_CYC - 1));

  // Free-running poll interval counter; its wrap is the frame trigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         poll_cnt <= '0;
    else if (poll_tick) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + PW'(1);
  end

  // State register plus the per-phase cycle counter and sample counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) cyc_cnt <= '0;
      else                                       cyc_cnt <= cyc_cnt + CW'(1);
      if (state == S_IDLE) bit_cnt <= '0;
      else if (sample)     bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Next-state and pad strobes; each phase ends on its last counted cycle.
  always_comb begin
    state_nxt   = state;
    nes_latch   = 1'b0;
    nes_clk     = 1'b0;
    frame_valid = 1'b0;
    sample      = 1'b0;
    case (state)
      S_IDLE:  if (poll_tick) state_nxt = S_LATCH;
      S_LATCH: begin
        nes_latch = 1'b1;
        if (last_latch) state_nxt = S_GAP;
      end
      S_GAP: if (last_half) begin
        sample    = 1'b1;
        state_nxt = S_HI;
      end
      S_HI: begin
        nes_clk = 1'b1;
        if (last_half) state_nxt = S_LO;
      end
      S_LO: if (last_half) begin
        sample    = 1'b1;
        state_nxt = (bit_cnt == 3'd7) ? S_DONE : S_HI;
      end
      S_DONE: begin
        frame_valid = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pad 1 synchronizer and shift register; first sample ends up in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 2'b11;
      shreg1 <= '0;
    end else begin
      sync1 <= {sync1[0], nes_data};
      if (sample) shreg1 <= {~sync1[1], shreg1[7:1]};
    end
  end

`ifdef NES_TWO_PAD_EN
  logic [1:0] sync2;
  logic [7:0] shreg2;

  // Pad 2 path, sampled on exactly the same cycles as pad 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync2  <= 2'b11;
      shreg2 <= '0;
    end else begin
      sync2 <= {sync2[0], nes_data2};
      if (sample) shreg2 <= {~sync2[1], shreg2[7:1]};
    end
  end

  assign pad2_word = shreg2;
`else
  assign pad2_word = 8'h00;
`endif

  // Publish both pads together only once the whole frame has been shifted in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               buttons <= '0;
    else if (state == S_DONE) buttons <= {pad2_word, shreg1};
  end

endmodule
